// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : Single-clock UART transmitter, one bit per clock, optional parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    input  logic       parity_en,
    input  logic       even_parity,
    output logic       tx,
    output logic       tx_busy
);

    // Each state names the line bit that will be driven at the coming edge.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] state_q,   state_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] cnt_q,     cnt_d;
    logic       par_en_q,  par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       tx_q,      tx_d;
    logic       busy_q,    busy_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // Busy still set in IDLE marks the edge that ends the stop bit;
                // a request seen on that edge is dropped.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (tx_start) begin
                    shift_d   = data_in;
                    par_en_d  = parity_en;
                    par_bit_d = (^data_in) ^ ~even_parity;
                    cnt_d     = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                tx_d    = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx_d    = par_bit_q;
                state_d = S_STOP;
            end
            S_STOP: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'd0;
            cnt_q     <= 3'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Directed and random frame checks for uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [7:0] data_in;
    logic       parity_en;
    logic       even_parity;
    logic       tx;
    logic       tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .data_in     (data_in),
        .parity_en   (parity_en),
        .even_parity (even_parity),
        .tx          (tx),
        .tx_busy     (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_bits[k-1] is the line value after edge Ek; nbits is 10 or 11.
    task automatic send_frame(input string name, input logic [7:0] d, input logic pen,
                              input logic ev, input logic [10:0] exp_bits, input int nbits,
                              input logic inject, input logic hold);
        @(negedge clk);
        tx_start    = 1'b1;
        data_in     = d;
        parity_en   = pen;
        even_parity = ev;
        @(posedge clk); #1;
        chk($sformatf("%s E0 tx", name), 32'(tx), 32'd1);
        chk($sformatf("%s E0 busy", name), 32'(tx_busy), 32'd1);
        for (int k = 1; k <= nbits; k++) begin
            @(negedge clk);
            tx_start    = hold | (inject && k == 4);
            data_in     = (inject && k == 4) ? 8'h3C : ~d;
            parity_en   = ~pen;
            even_parity = ~ev;
            @(posedge clk); #1;
            chk($sformatf("%s E%0d tx", name, k), 32'(tx), 32'(exp_bits[k-1]));
            chk($sformatf("%s E%0d busy", name, k), 32'(tx_busy), 32'd1);
        end
        @(negedge clk);
        tx_start = hold;
        @(posedge clk); #1;
        chk($sformatf("%s end busy", name), 32'(tx_busy), 32'd0);
        chk($sformatf("%s end tx", name), 32'(tx), 32'd1);
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            tx_start = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("%s idle%0d tx", name, i), 32'(tx), 32'd1);
            chk($sformatf("%s idle%0d busy", name, i), 32'(tx_busy), 32'd0);
        end
    endtask

    initial begin
        logic [7:0]  rd;
        logic        rp;
        logic        re;
        logic [10:0] rexp;

        rst         = 1'b1;
        tx_start    = 1'b0;
        data_in     = 8'h00;
        parity_en   = 1'b0;
        even_parity = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_check("post_reset", 2);

        // Directed frames with hand-computed bit streams (bit0 = E1)
        send_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 11'h34A, 10, 1'b0, 1'b0);
        send_frame("01_even",  8'h01, 1'b1, 1'b1, 11'h602, 11, 1'b0, 1'b0);
        send_frame("01_odd",   8'h01, 1'b1, 1'b0, 11'h402, 11, 1'b0, 1'b0);
        send_frame("ff_odd",   8'hFF, 1'b1, 1'b0, 11'h7FE, 11, 1'b0, 1'b0);
        send_frame("busy_inj", 8'hA5, 1'b0, 1'b0, 11'h34A, 10, 1'b1, 1'b0);
        idle_check("after_inj", 3);

        // Start held across the ending edge: ignored there, taken one cycle later
        send_frame("hold1",    8'h01, 1'b1, 1'b1, 11'h602, 11, 1'b0, 1'b1);
        send_frame("hold2",    8'hA5, 1'b0, 1'b0, 11'h34A, 10, 1'b0, 1'b0);
        idle_check("after_hold", 1);

        // Reset during idle
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rst tx", 32'(tx), 32'd1);
        chk("idle_rst busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-frame while the line is low
        @(negedge clk);
        tx_start  = 1'b1;
        data_in   = 8'h00;
        parity_en = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            tx_start = 1'b0;
        end
        #1;
        chk("midframe low tx", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midframe_rst tx", 32'(tx), 32'd1);
        chk("midframe_rst busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        idle_check("after_abort", 14);

        // Random back-to-back frames against a reference frame builder
        for (int n = 0; n < 100; n++) begin
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            if (rp)
                rexp = {1'b1, ~^{rd, re}, rd, 1'b0};
            else
                rexp = {1'b0, 1'b1, rd, 1'b0};
            send_frame($sformatf("rnd%0d", n), rd, rp, re, rexp, rp ? 11 : 10, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
